// File: rtl/id_hazard_ctrl_if.sv
// Decode-stage hazard bus: ID operand/pipeline-destination info in, stall/forward/mult-div status out.
interface id_hazard_ctrl_if;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       id_jmp_reg;
    logic       id_muldiv;
    logic       id_is_div;
    logic       id_read_hilo;
    logic [4:0] ex_wreg;
    logic       ex_regwrite;
    logic       ex_memread;
    logic [4:0] mem_wreg;
    logic       mem_regwrite;
    logic       mem_memread;
    logic [4:0] wb_wreg;
    logic       wb_regwrite;
    logic       stall;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       muldiv_start;
    logic       muldiv_busy;
    logic       muldiv_done;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_jmp_reg,
               id_muldiv, id_is_div, id_read_hilo,
               ex_wreg, ex_regwrite, ex_memread,
               mem_wreg, mem_regwrite, mem_memread,
               wb_wreg, wb_regwrite,
        input  stall, fwd_a, fwd_b, muldiv_start, muldiv_busy, muldiv_done
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_jmp_reg,
               id_muldiv, id_is_div, id_read_hilo,
               ex_wreg, ex_regwrite, ex_memread,
               mem_wreg, mem_regwrite, mem_memread,
               wb_wreg, wb_regwrite,
        output stall, fwd_a, fwd_b, muldiv_start, muldiv_busy, muldiv_done
    );
endinterface

// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard controller: operand forwarding selects, load-use / jr stalls,
// and scheduling of the shared multi-cycle mult/div unit with HI/LO interlock.
module id_hazard_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 33
) (
    input  logic            clk,
    input  logic            rst_n,
    id_hazard_ctrl_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

    md_state_e  state_q, state_d;
    logic [5:0] cnt_q, cnt_d;

    logic       rs_ex_s, rt_ex_s, rs_mem_s, rt_mem_s;
    logic       load_use_s, jr_hazard_s, hazard_nonmd_s, hilo_hazard_s;
    logic       stall_s, start_s, done_s, issue_s;
    logic [1:0] fwd_a_s, fwd_b_s;
    logic       unused_wb_s;

    // The register file writes before it reads, so WB never needs a forward path.
    assign unused_wb_s = ^{bus.wb_wreg, bus.wb_regwrite};

    assign rs_ex_s  = bus.id_use_rs & bus.ex_regwrite  & (bus.ex_wreg  != 5'd0) & (bus.ex_wreg  == bus.id_rs);
    assign rt_ex_s  = bus.id_use_rt & bus.ex_regwrite  & (bus.ex_wreg  != 5'd0) & (bus.ex_wreg  == bus.id_rt);
    assign rs_mem_s = bus.id_use_rs & bus.mem_regwrite & (bus.mem_wreg != 5'd0) & (bus.mem_wreg == bus.id_rs);
    assign rt_mem_s = bus.id_use_rt & bus.mem_regwrite & (bus.mem_wreg != 5'd0) & (bus.mem_wreg == bus.id_rt);

    // Forward selects: the younger producer (EX) wins over MEM.
    always_comb begin
        fwd_a_s = 2'b00;
        fwd_b_s = 2'b00;
        if (rs_ex_s) begin
            fwd_a_s = 2'b01;
        end else if (rs_mem_s) begin
            fwd_a_s = 2'b10;
        end else begin
            fwd_a_s = 2'b00;
        end
        if (rt_ex_s) begin
            fwd_b_s = 2'b01;
        end else if (rt_mem_s) begin
            fwd_b_s = 2'b10;
        end else begin
            fwd_b_s = 2'b00;
        end
    end

    // jr/jalr read rs in ID, so even a non-load in EX is too late; a load in MEM is too.
    assign load_use_s     = bus.id_valid & bus.ex_memread & (rs_ex_s | rt_ex_s);
    assign jr_hazard_s    = bus.id_valid & bus.id_jmp_reg & (rs_ex_s | (rs_mem_s & bus.mem_memread));
    assign hazard_nonmd_s = load_use_s | jr_hazard_s;
    assign hilo_hazard_s  = bus.id_valid & (bus.id_read_hilo | bus.id_muldiv) & (state_q == ST_BUSY);
    assign stall_s        = hazard_nonmd_s | hilo_hazard_s;
    assign issue_s        = bus.id_valid & bus.id_muldiv & ~hazard_nonmd_s;

    // Mult/div sequencing: next state, down-counter and start/done pulses.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start_s = 1'b0;
        done_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (issue_s) begin
                    start_s = 1'b1;
                    cnt_d   = bus.id_is_div ? DIV_LOAD : MUL_LOAD;
                    state_d = ST_BUSY;
                end else begin
                    cnt_d   = 6'd0;
                end
            end
            ST_BUSY: begin
                if (cnt_q == 6'd0) begin
                    done_s  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q - 6'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 6'd0;
            end
        endcase
    end

    // State register; an asynchronous reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.stall        = rst_n & stall_s;
    assign bus.fwd_a        = {2{rst_n}} & fwd_a_s;
    assign bus.fwd_b        = {2{rst_n}} & fwd_b_s;
    assign bus.muldiv_start = rst_n & start_s;
    assign bus.muldiv_busy  = rst_n & (state_q == ST_BUSY);
    assign bus.muldiv_done  = rst_n & done_s;

endmodule
